nway_cache_fsm: RTL and testbench

NWAY_CACHE_FSM -- requirements
Module: nway_cache_fsm

---
 rtl/nway_cache_fsm.sv | 216 +++++++++++++++++++++
 tb/tb_nway_cache_fsm.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nway_cache_fsm.sv
// rtl/nway_cache_fsm.sv - N-way set-associative write-back cache controller
module nway_cache_fsm #(
  parameter int INDEX_W = 10,
  parameter int WAYS    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_req_valid,
  input  logic         cpu_req_rw,
  input  logic [31:0]  cpu_req_addr,
  input  logic [31:0]  cpu_req_data,
  input  logic [3:0]   cpu_req_be,
  output logic         cpu_res_ready,
  output logic [31:0]  cpu_res_data,
  output logic         mem_req_valid,
  output logic         mem_req_rw,
  output logic [31:0]  mem_req_addr,
  output logic [127:0] mem_req_data,
  input  logic         mem_data_ready,
  input  logic [127:0] mem_data_data,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = 28 - INDEX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COMPARE    = 2'd1,
    WRITE_BACK = 2'd2,
    ALLOCATE   = 2'd3
  } state_t;

  state_t state, next_state;

  // Per-set, per-way storage; only the metadata bits are cleared on reset.
  logic [127:0]     line_mem  [SETS][WAYS];
  logic [TAG_W-1:0] tag_mem   [SETS][WAYS];
  logic [WAYS-1:0]  valid_mem [SETS];
  logic [WAYS-1:0]  dirty_mem [SETS];
  logic [WAY_W-1:0] ptr_mem   [SETS];

  // Latched request and miss bookkeeping.
  logic [31:0]      req_addr;
  logic [31:0]      req_data;
  logic             req_rw;
  logic [3:0]       req_be;
  logic             refill;
  logic [WAY_W-1:0] vic_way;
  logic             vic_by_ptr;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  logic [1:0]         word;
  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic               any_invalid;
  logic [WAY_W-1:0]   free_way;
  logic [WAY_W-1:0]   sel_way;
  logic [127:0]       hit_line;
  logic [127:0]       merged;
  logic [31:0]        hit_word;
  logic               unused_ok;

  assign idx      = req_addr[INDEX_W+3:4];
  assign req_tag  = req_addr[31:INDEX_W+4];
  assign word     = req_addr[3:2];
  assign hit_line = line_mem[idx][hit_way];
  assign hit_word = hit_line[{word, 5'b0} +: 32];
  // The byte offset inside a word plays no part in addressing.
  assign unused_ok = ^req_addr[1:0];

  // Tag match across all ways of the addressed set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_mem[idx][w] && (tag_mem[idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim choice: lowest invalid way, else the set's round-robin pointer.
  always_comb begin
    any_invalid = 1'b0;
    free_way    = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_mem[idx][w]) begin
        any_invalid = 1'b1;
        free_way    = WAY_W'(w);
      end
    end
    sel_way = any_invalid ? free_way : ptr_mem[idx];
  end

  // Byte-enable merge of the write word into the hit line.
  always_comb begin
    merged = hit_line;
    for (int b = 0; b < 4; b++) begin
      if (req_be[b]) begin
        merged[{word, 5'b0} + 7'(b * 8) +: 8] = req_data[b*8 +: 8];
      end
    end
  end

  // Next-state logic and all CPU/memory-side outputs.
  always_comb begin
    next_state    = state;
    cpu_res_ready = 1'b0;
    cpu_res_data  = '0;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    case (state)
      IDLE: begin
        if (cpu_req_valid) next_state = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          cpu_res_ready = 1'b1;
          if (!req_rw) cpu_res_data = hit_word;
          next_state = IDLE;
        end else if (valid_mem[idx][sel_way] && dirty_mem[idx][sel_way]) begin
          next_state = WRITE_BACK;
        end else begin
          next_state = ALLOCATE;
        end
      end
      WRITE_BACK: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {tag_mem[idx][vic_way], idx, 4'b0};
        mem_req_data  = line_mem[idx][vic_way];
        if (mem_data_ready) next_state = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_addr[31:4], 4'b0};
        if (mem_data_ready) next_state = COMPARE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register, request latch, victim latch and hit/miss counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_addr   <= '0;
      req_data   <= '0;
      req_rw     <= 1'b0;
      req_be     <= '0;
      refill     <= 1'b0;
      vic_way    <= '0;
      vic_by_ptr <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && cpu_req_valid) begin
        req_addr <= cpu_req_addr;
        req_data <= cpu_req_data;
        req_rw   <= cpu_req_rw;
        req_be   <= cpu_req_be;
        refill   <= 1'b0;
      end
      if (state == COMPARE) begin
        if (hit) begin
          if (!refill && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
        end else begin
          if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
          vic_way    <= sel_way;
          vic_by_ptr <= !any_invalid;
        end
      end
      if (state == ALLOCATE && mem_data_ready) refill <= 1'b1;
    end
  end

  // Valid/dirty bits and victim pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        ptr_mem[s]   <= '0;
      end
    end else begin
      if (state == COMPARE && hit && req_rw && req_be != 4'b0) begin
        dirty_mem[idx][hit_way] <= 1'b1;
      end
      if (state == ALLOCATE && mem_data_ready) begin
        valid_mem[idx][vic_way] <= 1'b1;
        dirty_mem[idx][vic_way] <= 1'b0;
        if (WAYS > 1 && vic_by_ptr) ptr_mem[idx] <= ptr_mem[idx] + WAY_W'(1);
      end
    end
  end

  // Line and tag arrays; reset forces IDLE so no write can land while rst is high.
  always_ff @(posedge clk) begin
    if (state == COMPARE && hit && req_rw) begin
      line_mem[idx][hit_way] <= merged;
    end
    if (state == ALLOCATE && mem_data_ready) begin
      line_mem[idx][vic_way] <= mem_data_data;
      tag_mem[idx][vic_way]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_nway_cache_fsm.sv
// tb/tb_nway_cache_fsm.sv - randomized bench for nway_cache_fsm against a transparent-memory model
module tb_nway_cache_fsm;

  localparam int IW   = 4;
  localparam int NW   = 2;
  localparam int SETS = 1 << IW;
  localparam int TW   = 28 - IW;

  logic         clk;
  logic         rst;
  logic         cpu_req_valid;
  logic         cpu_req_rw;
  logic [31:0]  cpu_req_addr;
  logic [31:0]  cpu_req_data;
  logic [3:0]   cpu_req_be;
  logic         cpu_res_ready;
  logic [31:0]  cpu_res_data;
  logic         mem_req_valid;
  logic         mem_req_rw;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_data_ready;
  logic [127:0] mem_data_data;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  nway_cache_fsm #(.INDEX_W(IW), .WAYS(NW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw), .cpu_req_addr(cpu_req_addr),
    .cpu_req_data(cpu_req_data), .cpu_req_be(cpu_req_be),
    .cpu_res_ready(cpu_res_ready), .cpu_res_data(cpu_res_data),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_data_ready(mem_data_ready), .mem_data_data(mem_data_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: residency per set/way plus two memory images. bmem is what the
  // memory port holds; shadow is the architectural view a CPU should observe.
  bit               m_valid [SETS][NW];
  bit               m_dirty [SETS][NW];
  logic [TW-1:0]    m_tag   [SETS][NW];
  int               m_ptr   [SETS];
  int               m_hits;
  int               m_misses;
  logic [127:0]     bmem    [logic [27:0]];
  logic [127:0]     shadow  [logic [27:0]];

  function automatic logic [127:0] init_line(input logic [27:0] a);
    return {~{4'h0, a}, {4'h1, a}, {4'h2, a} ^ 32'hA5A5_A5A5, {4'h3, a} * 32'h9E37_79B1};
  endfunction

  function automatic logic [127:0] get_bmem(input logic [27:0] a);
    return bmem.exists(a) ? bmem[a] : init_line(a);
  endfunction

  function automatic logic [127:0] get_shadow(input logic [27:0] a);
    return shadow.exists(a) ? shadow[a] : get_bmem(a);
  endfunction

  task automatic do_reset();
    rst            = 1'b1;
    cpu_req_valid  = 1'b0;
    mem_data_ready = 1'b0;
    #1;
    check_eq("rst_res_ready", cpu_res_ready, 1'b0);
    check_eq("rst_res_data", cpu_res_data, 32'h0);
    check_eq("rst_mem_valid", mem_req_valid, 1'b0);
    check_eq("rst_hit_count", hit_count, 32'h0);
    check_eq("rst_miss_count", miss_count, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
    m_hits   = 0;
    m_misses = 0;
    shadow.delete();
  endtask

  task automatic access(input bit rw, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input int delay, input bit abort_wb);
    int s, hw, vic, cyc, ph, nph, wcnt;
    bit hit, by_ptr, need_wb, done, is_wb;
    logic [TW-1:0]  tg;
    logic [27:0]    la, wb_la;
    logic [127:0]   ln;
    logic [31:0]    exp_rd, first_addr;
    s  = int'(addr[IW+3:4]);
    tg = addr[31:IW+4];
    la = addr[31:4];
    hit = 1'b0;
    hw  = 0;
    for (int w = 0; w < NW; w++)
      if (m_valid[s][w] && m_tag[s][w] == tg) begin hit = 1'b1; hw = w; end
    vic = -1; by_ptr = 1'b0; need_wb = 1'b0; wb_la = '0;
    if (!hit) begin
      for (int w = NW - 1; w >= 0; w--) if (!m_valid[s][w]) vic = w;
      if (vic < 0) begin by_ptr = 1'b1; vic = m_ptr[s]; end
      need_wb = m_valid[s][vic] && m_dirty[s][vic];
      wb_la   = {m_tag[s][vic], addr[IW+3:4]};
    end
    nph    = hit ? 0 : (need_wb ? 2 : 1);
    ln     = get_shadow(la);
    exp_rd = ln[int'(addr[3:2]) * 32 +: 32];

    cpu_req_valid = 1'b1; cpu_req_rw = rw; cpu_req_addr = addr;
    cpu_req_data  = data; cpu_req_be = be;
    @(negedge clk);
    cyc = 0; ph = 0; wcnt = 0; done = 1'b0; first_addr = '0;
    while (!done && cyc < 300) begin
      mem_data_ready = 1'b0;
      mem_data_data  = {$urandom, $urandom, $urandom, $urandom};
      if (cpu_res_ready) begin
        if (hit) check_eq("hit_latency", cyc, 0);
        check_eq("mem_phases", ph, nph);
        if (!rw) check_eq("rd_data", cpu_res_data, exp_rd);
        check_eq("done_mem_valid", mem_req_valid, 1'b0);
        done = 1'b1;
        cpu_req_valid = 1'b0;
      end else begin
        check_eq("res_data_zero", cpu_res_data, 32'h0);
        cpu_req_valid = 1'($urandom); cpu_req_rw = 1'($urandom); cpu_req_addr = $urandom;
        cpu_req_data = $urandom; cpu_req_be = 4'($urandom);
        if (mem_req_valid) begin
          is_wb = need_wb && ph == 0;
          if (wcnt == 0) begin
            check_eq("unexpected_req", ph < nph, 1'b1);
            check_eq(is_wb ? "wb_rw" : "fill_rw", mem_req_rw, is_wb);
            check_eq(is_wb ? "wb_addr" : "fill_addr", mem_req_addr,
                     is_wb ? {wb_la, 4'h0} : {la, 4'h0});
            if (is_wb) check_eq("wb_data", mem_req_data, get_shadow(wb_la));
            first_addr = mem_req_addr;
          end else begin
            check_eq("req_stable", mem_req_addr, first_addr);
          end
          if (abort_wb && is_wb && wcnt == 2) begin
            do_reset();
            return;
          end
          if (wcnt >= delay) begin
            mem_data_ready = 1'b1;
            if (is_wb) bmem[wb_la] = get_shadow(wb_la);
            else mem_data_data = get_bmem(la);
            wcnt = 0;
            ph++;
          end else begin
            wcnt++;
          end
        end else if (cyc == 0) begin
          mem_data_ready = 1'($urandom);
        end
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done) begin
      check_eq("timeout", done, 1'b1);
      do_reset();
      return;
    end
    if (!hit) begin
      m_misses++;
      m_valid[s][vic] = 1'b1;
      m_dirty[s][vic] = 1'b0;
      m_tag[s][vic]   = tg;
      if (by_ptr) m_ptr[s] = (m_ptr[s] + 1) % NW;
      hw = vic;
    end else begin
      m_hits++;
    end
    if (rw) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ln[int'(addr[3:2]) * 32 + b * 8 +: 8] = data[b*8 +: 8];
      shadow[la] = ln;
      if (be != 4'b0) m_dirty[s][hw] = 1'b1;
    end
    @(negedge clk);
    check_eq("hit_count", hit_count, m_hits);
    check_eq("miss_count", miss_count, m_misses);
    check_eq("idle_res_ready", cpu_res_ready, 1'b0);
    check_eq("idle_mem_valid", mem_req_valid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] h0;
    logic [23:0] ta, tb_, tc, td, te;
    cpu_req_valid = 1'b0; cpu_req_rw = 1'b0; cpu_req_addr = '0;
    cpu_req_data  = '0;   cpu_req_be = '0;
    mem_data_ready = 1'b0; mem_data_data = '0;
    do_reset();

    // Cold read miss of 0x10 with a known fill line.
    bmem[28'h1] = 128'h4444_3333_2222_1111;
    access(1'b0, 32'h0000_0010, 32'h0, 4'h0, 2, 1'b0);
    check_eq("first_miss_count", miss_count, 32'd1);
    check_eq("first_hit_count", hit_count, 32'd0);

    // Partial write into a resident word, then read back.
    access(1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 0, 1'b0);
    h0 = hit_count;
    access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b0011, 0, 1'b0);
    access(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 1'b0);
    check_eq("merge_hits", hit_count - h0, 32'd2);
    // Zero byte-enable write is a no-op hit.
    access(1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 0, 1'b0);
    access(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 1'b0);

    // Two-way conflict in set 0 with a dirty victim, then pointer-driven eviction.
    do_reset();
    ta = 24'h00_0011; tb_ = 24'h00_0022; tc = 24'h00_0033; td = 24'h00_0044; te = 24'h00_0055;
    access(1'b0, {ta, 8'h00}, 32'h0, 4'h0, 1, 1'b0);
    access(1'b0, {tb_, 8'h00}, 32'h0, 4'h0, 1, 1'b0);
    access(1'b1, {ta, 8'h04}, 32'hCAFE_F00D, 4'hF, 0, 1'b0);
    access(1'b0, {tc, 8'h00}, 32'h0, 4'h0, 1, 1'b0);
    access(1'b0, {td, 8'h08}, 32'h0, 4'h0, 0, 1'b0);
    // Long memory stall during ALLOCATE.
    access(1'b0, {te, 8'h0C}, 32'h0, 4'h0, 20, 1'b0);

    // Reset in the middle of a write-back; the dirty data must be dropped.
    do_reset();
    access(1'b0, {ta, 8'h00}, 32'h0, 4'h0, 0, 1'b0);
    access(1'b1, {ta, 8'h00}, 32'h5555_AAAA, 4'hF, 0, 1'b0);
    access(1'b0, {tb_, 8'h00}, 32'h0, 4'h0, 0, 1'b0);
    access(1'b0, {tc, 8'h00}, 32'h0, 4'h0, 5, 1'b1);
    access(1'b0, {ta, 8'h00}, 32'h0, 4'h0, 0, 1'b0);
    check_eq("post_abort_miss", miss_count, 32'd1);

    // Randomized traffic over a few sets and tags to provoke evictions.
    for (int i = 0; i < 400; i++) begin
      logic [23:0] t;
      logic [3:0]  st;
      logic [1:0]  wd;
      t  = 24'($urandom_range(0, 3) * 32'h0001_0203 + 32'h5);
      st = 4'($urandom_range(0, 3));
      wd = 2'($urandom_range(0, 3));
      access(1'($urandom), {t, st, wd, 2'b00}, $urandom, 4'($urandom),
             int'($urandom_range(0, 3)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
